// File: rtl/trace_pkg.sv
// trace_pkg: state encoding, EBREAK opcode and record layout for commit_trace_buffer.
// The record widens to carry a timestamp when TRACE_TIMESTAMP_EN is defined.
package trace_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t CAPTURE = 2'd1;
  localparam state_t STOPPED = 2'd2;
  localparam logic [31:0] RV_EBREAK = 32'h00100073;
  localparam int OFF_RW    = 0;
  localparam int OFF_ALU   = 1;
  localparam int OFF_INSTR = 33;
  localparam int OFF_PC    = 65;
  localparam int OFF_TS    = 97;
`ifdef TRACE_TIMESTAMP_EN
  localparam int TRACE_REC_W = 129;
`else
  localparam int TRACE_REC_W = 97;
`endif
endpackage

// File: rtl/commit_trace_buffer_if.sv
// commit_trace_buffer_if: retire observation inputs and the valid/ready drain port.
// out_ts exists only when TRACE_TIMESTAMP_EN is defined.
interface commit_trace_buffer_if;
  logic        retire_valid;
  logic [31:0] pc_in;
  logic [31:0] instr_in;
  logic [31:0] alu_in;
  logic        reg_write_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_alu;
  logic        out_reg_write;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] out_ts;
  modport slave (input retire_valid, pc_in, instr_in, alu_in, reg_write_in, out_ready,
                 output out_valid, out_pc, out_instr, out_alu, out_reg_write, out_ts);
  modport master (output retire_valid, pc_in, instr_in, alu_in, reg_write_in, out_ready,
                  input out_valid, out_pc, out_instr, out_alu, out_reg_write, out_ts);
`else
  modport slave (input retire_valid, pc_in, instr_in, alu_in, reg_write_in, out_ready,
                 output out_valid, out_pc, out_instr, out_alu, out_reg_write);
  modport master (output retire_valid, pc_in, instr_in, alu_in, reg_write_in, out_ready,
                  input out_valid, out_pc, out_instr, out_alu, out_reg_write);
`endif
endinterface

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO with a registered head; a write becomes visible one edge
// later, and the head register holds the last popped value while empty.
module trace_fifo #(
  parameter int W     = 97,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] head_q;
  logic [AW:0]  wptr_q, rptr_q, rptr_d;
  logic         valid_q, pop, wr, more;
  always_comb begin
    level_o = wptr_q - rptr_q;
    full_o  = level_o == (AW+1)'(DEPTH);
    empty_o = level_o == '0;
    pop     = pop_i & valid_q;
    wr      = push_i & (~full_o | pop);
    rptr_d  = rptr_q + (AW+1)'(pop);
    more    = wptr_q != rptr_d;
    dout_o  = head_q;
    valid_o = valid_q;
  end
  always_ff @(posedge clk)
    if (wr && !flush_i) mem_q[wptr_q[AW-1:0]] <= din_i;
  // Head is reloaded only from entries written before this edge, giving one cycle of latency.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      valid_q <= 1'b0;
      head_q  <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_q + (AW+1)'(wr);
      rptr_q  <= rptr_d;
      valid_q <= more;
      if (more) head_q <= mem_q[rptr_d[AW-1:0]];
    end
endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: captures retired-instruction records into a FIFO under an arm/stop FSM
// and counts overflow drops. TRACE_TIMESTAMP_EN adds a cycle timestamp per record (out_ts).
module commit_trace_buffer import trace_pkg::*; #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter bit STOP_ON_FULL = 1'b0,
  parameter bit EBREAK_STOP  = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                arm,
  input  logic                clear,
  commit_trace_buffer_if.slave tr,
  output logic [ADDR_W:0]     level,
  output logic [15:0]         drop_cnt,
  output logic [1:0]          state
);
  state_t state_q, state_d;
  logic [15:0] drop_q;
  logic [TRACE_REC_W-1:0] rec, head;
  logic push, pop, drop, full, empty, ebrk, fill;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ts_q <= '0;
    else ts_q <= ts_q + 32'd1;
  assign tr.out_ts = head[OFF_TS +: 32];
`endif
  always_comb begin
    rec = '0;
    rec[OFF_PC +: 32]    = tr.pc_in;
    rec[OFF_INSTR +: 32] = tr.instr_in;
    rec[OFF_ALU +: 32]   = tr.alu_in;
    rec[OFF_RW]          = tr.reg_write_in;
`ifdef TRACE_TIMESTAMP_EN
    rec[OFF_TS +: 32]    = ts_q;
`endif
  end
  trace_fifo #(.W(TRACE_REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(reset_n), .push_i(push), .pop_i(pop), .flush_i(clear),
    .din_i(rec), .dout_o(head), .valid_o(tr.out_valid), .full_o(full),
    .empty_o(empty), .level_o(level)
  );
  assign tr.out_pc        = head[OFF_PC +: 32];
  assign tr.out_instr     = head[OFF_INSTR +: 32];
  assign tr.out_alu       = head[OFF_ALU +: 32];
  assign tr.out_reg_write = head[OFF_RW];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  // Full-stop looks at the occupancy after this edge so the filling push never counts as a drop.
  always_comb begin
    ebrk    = EBREAK_STOP && push && tr.instr_in == RV_EBREAK;
    fill    = STOP_ON_FULL && (full || (level == (ADDR_W+1)'(DEPTH-1) && push && !pop));
    state_d = clear ? IDLE :
              (state_q != CAPTURE && arm) ? CAPTURE :
              (state_q == CAPTURE && (ebrk || fill)) ? STOPPED : state_q;
  end
  always_comb begin
    push     = (state_q == CAPTURE) & tr.retire_valid;
    pop      = tr.out_valid & tr.out_ready;
    drop     = push & full & ~pop & ~clear & ~empty;
    state    = state_q;
    drop_cnt = drop_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) drop_q <= '0;
    else if (clear) drop_q <= '0;
    else if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: table vectors, directed corner sequences and random traffic
// checked against a queue-based reference model of the trace buffer.
module tb_commit_trace_buffer;
  localparam logic [31:0] EBRK = 32'h00100073;
  localparam logic [31:0] NOP  = 32'h00000013;
  logic clk = 1'b0, reset_n = 1'b0;
  logic arm = 1'b0, clr = 1'b0, rv = 1'b0, rw = 1'b0, rdy = 1'b0;
  logic [31:0] pc = '0, instr = '0, alu = '0;
  logic [4:0] lvl0, lvl1;
  logic [15:0] drop0, drop1;
  logic [1:0] st0, st1;
  int n_chk = 0, n_fail = 0;
  commit_trace_buffer_if i0();
  commit_trace_buffer_if i1();
  assign {i0.retire_valid, i0.pc_in, i0.instr_in, i0.alu_in, i0.reg_write_in, i0.out_ready} = {rv, pc, instr, alu, rw, rdy};
  assign {i1.retire_valid, i1.pc_in, i1.instr_in, i1.alu_in, i1.reg_write_in, i1.out_ready} = {rv, pc, instr, alu, rw, rdy};
  commit_trace_buffer #(.DEPTH(16), .STOP_ON_FULL(1'b0), .EBREAK_STOP(1'b1)) u0 (
    .clk(clk), .reset_n(reset_n), .arm(arm), .clear(clr), .tr(i0), .level(lvl0), .drop_cnt(drop0), .state(st0));
  commit_trace_buffer #(.DEPTH(16), .STOP_ON_FULL(1'b1), .EBREAK_STOP(1'b1)) u1 (
    .clk(clk), .reset_n(reset_n), .arm(arm), .clear(clr), .tr(i1), .level(lvl1), .drop_cnt(drop1), .state(st1));
  always #5 clk = ~clk;
  typedef struct packed {logic [31:0] pc, instr, alu; logic rw;} rec_t;
  rec_t mq[$];
  rec_t m_head;
  bit m_valid;
  int m_state, m_drop;
  typedef struct {logic a, c, r, d; logic [31:0] pc; int st, lvl; logic vld; logic [31:0] opc;} vec_t;
  vec_t tbl[7];
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask
  task automatic model_reset();
    mq.delete();
    m_valid = 1'b0;
    m_head = '0;
    m_drop = 0;
    m_state = 0;
  endtask
  task automatic model_step();
    bit popv, pushv;
    if (clr) begin
      mq.delete();
      m_valid = 1'b0;
      m_drop = 0;
      m_state = 0;
      return;
    end
    popv = m_valid && rdy;
    pushv = m_state == 1 && rv;
    if (popv) void'(mq.pop_front());
    m_valid = mq.size() > 0;
    if (m_valid) m_head = mq[0];
    if (pushv) begin
      if (mq.size() < 16) mq.push_back({pc, instr, alu, rw});
      else if (m_drop < 65535) m_drop++;
    end
    if (m_state != 1 && arm) m_state = 1;
    else if (m_state == 1 && pushv && instr == EBRK) m_state = 2;
  endtask
  task automatic model_cmp();
    chk("state", st0, m_state);
    chk("level", lvl0, mq.size());
    chk("out_valid", i0.out_valid, m_valid);
    chk("drop_cnt", drop0, m_drop);
    chk("head_rec", {i0.out_pc, i0.out_instr, i0.out_alu, i0.out_reg_write}, m_head);
  endtask
  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_reset(); else model_step();
    @(negedge clk);
    model_cmp();
  endtask
  task automatic cyc(input logic a, c, r, d, input logic [31:0] p, input logic [31:0] ins);
    {arm, clr, rv, rdy, pc, instr, alu, rw} = {a, c, r, d, p, ins, p ^ 32'h1000, 1'b1};
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0] = '{1, 0, 0, 1, 32'h0, 1, 0, 0, 32'h0};
    tbl[1] = '{0, 0, 1, 1, 32'h0, 1, 1, 0, 32'h0};
    tbl[2] = '{0, 0, 1, 1, 32'h4, 1, 2, 1, 32'h0};
    tbl[3] = '{0, 0, 1, 1, 32'h8, 1, 2, 1, 32'h4};
    tbl[4] = '{0, 0, 0, 1, 32'h0, 1, 1, 1, 32'h8};
    tbl[5] = '{0, 0, 0, 1, 32'h0, 1, 0, 0, 32'h8};
    tbl[6] = '{0, 0, 0, 1, 32'h0, 1, 0, 0, 32'h8};
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_state", st0, 0);
    chk("rst_level", lvl0, 0);
    chk("rst_valid", i0.out_valid, 0);
    chk("rst_pc", i0.out_pc, 0);
    reset_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      cyc(tbl[k].a, tbl[k].c, tbl[k].r, tbl[k].d, tbl[k].pc, NOP);
      chk($sformatf("tbl%0d_state", k), st0, tbl[k].st);
      chk($sformatf("tbl%0d_level", k), lvl0, tbl[k].lvl);
      chk($sformatf("tbl%0d_valid", k), i0.out_valid, tbl[k].vld);
      chk($sformatf("tbl%0d_pc", k), i0.out_pc, tbl[k].opc);
    end
    cyc(0, 1, 0, 0, 0, NOP);
    cyc(1, 0, 0, 0, 0, NOP);
    for (int k = 0; k < 20; k++) cyc(0, 0, 1, 0, 32'h100 + 4 * k, NOP);
    chk("ovf_level0", lvl0, 16);
    chk("ovf_drop0", drop0, 4);
    chk("sof_level1", lvl1, 16);
    chk("sof_drop1", drop1, 0);
    chk("sof_state1", st1, 2);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d_pc", k), i0.out_pc, 32'h100 + 4 * k);
      cyc(0, 0, 0, 1, 0, NOP);
    end
    chk("drained_level", lvl0, 0);
    cyc(0, 1, 0, 0, 0, NOP);
    cyc(1, 0, 0, 0, 0, NOP);
    cyc(0, 0, 1, 0, 32'h40, EBRK);
    chk("ebrk_state", st0, 2);
    cyc(0, 0, 1, 0, 32'h44, NOP);
    chk("ebrk_level", lvl0, 1);
    chk("ebrk_pc", i0.out_pc, 32'h40);
    chk("ebrk_instr", i0.out_instr, EBRK);
    cyc(0, 1, 0, 0, 0, NOP);
    cyc(1, 0, 0, 0, 0, NOP);
    for (int k = 0; k < 17; k++) cyc(0, 0, 1, 0, 32'h200 + 4 * k, NOP);
    chk("full_drop", drop0, 1);
    cyc(0, 0, 1, 1, 32'h300, NOP);
    chk("pushpop_level", lvl0, 16);
    chk("pushpop_drop", drop0, 1);
    cyc(0, 1, 1, 1, 32'h304, NOP);
    chk("clr_level", lvl0, 0);
    chk("clr_state", st0, 0);
    chk("clr_drop", drop0, 0);
    cyc(1, 0, 0, 0, 0, NOP);
    for (int k = 0; k < 5; k++) cyc(0, 0, 1, 0, 32'h500 + 4 * k, NOP);
    cyc(0, 0, 0, 0, 0, NOP);
    chk("pre_rst_level", lvl0, 5);
    rdy = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", i0.out_valid, 0);
    chk("arst_level", lvl0, 0);
    chk("arst_state", st0, 0);
    model_reset();
    tick();
    reset_n = 1'b1;
`ifdef TRACE_TIMESTAMP_EN
    begin
      logic [31:0] t0;
      cyc(1, 0, 0, 0, 0, NOP);
      cyc(0, 0, 1, 0, 32'h600, NOP);
      cyc(0, 0, 1, 0, 32'h604, NOP);
      cyc(0, 0, 0, 0, 0, NOP);
      t0 = i0.out_ts;
      cyc(0, 0, 0, 1, 0, NOP);
      chk("ts_delta", i0.out_ts - t0, 1);
      cyc(0, 1, 0, 0, 0, NOP);
    end
`endif
    for (int k = 0; k < 1500; k++) begin
      {arm, clr, rv, rdy} = {$urandom_range(19) == 0, $urandom_range(96) == 0, $urandom_range(3) != 0, $urandom_range(2) != 0};
      pc = $urandom;
      instr = ($urandom_range(15) == 0) ? EBRK : $urandom;
      alu = $urandom;
      rw = 1'($urandom);
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Sits directly downstream of cpu_top and consumes its retire observation ports: pc_out, instr_out, alu_out and reg_write_out.
- Captures one trace record per retired instruction into an on-chip FIFO. A debug consumer (UART bridge or testbench) drains the FIFO through a valid/ready port.
- Arm/stop FSM. Stops automatically on EBREAK, and optionally on full.
- Counts records lost to overflow.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of 2, minimum 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, do not override.
- STOP_ON_FULL, 0: 1 stops capture when the FIFO fills; 0 drops new records and counts them.
- EBREAK_STOP, 1: 1 stops capture after an EBREAK (32'h00100073) record is stored.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- arm  in  1  single-cycle pulse; IDLE->CAPTURE.
- clear  in  1  single-cycle pulse; flushes FIFO, zeroes drop_cnt, goes to IDLE.
- retire_valid  in  1  CPU retired an instruction this cycle; tie high for single-cycle core after reset.
- pc_in  in  32  from cpu_top pc_out.
- instr_in  in  32  from cpu_top instr_out.
- alu_in  in  32  from cpu_top alu_out.
- reg_write_in  in  1  from cpu_top reg_write_out.
- out_valid  out  1  head record available.
- out_ready  in  1  consumer accepts head.
- out_pc  out  32  head record PC.
- out_instr  out  32  head record instruction.
- out_alu  out  32  head record ALU result.
- out_reg_write  out  1  head record write-enable.
- level  out  ADDR_W+1  current occupancy, 0..DEPTH.
- drop_cnt  out  16  records lost while full; saturates at 16'hFFFF.
- state  out  2  FSM state: IDLE=0, CAPTURE=1, STOPPED=2.

Behaviour:
- Reset (async assert, sync release): state=IDLE, FIFO empty, level=0, out_valid=0, all out_* data=0, drop_cnt=0.
- push = (state==CAPTURE) & retire_valid.
- pop = out_valid & out_ready. Data out_* is valid only while out_valid=1. When empty, it holds the last popped value.
- Latency: a record pushed at edge N is visible with out_valid=1 after edge N+1 if the FIFO was empty. The record is the registered FIFO head. No combinational path from the retire inputs to out_*.
- Order is strict FIFO.
- Drain works in every state, including IDLE and STOPPED.
- FSM transitions:
  - IDLE: arm -> CAPTURE.
  - CAPTURE: EBREAK_STOP=1 and push with instr_in==32'h00100073 -> record stored, then STOPPED next cycle. STOP_ON_FULL=1 and level reaches DEPTH -> STOPPED.
  - STOPPED: arm -> CAPTURE; FIFO contents retained.
  - Any state: clear -> IDLE.
  - clear has priority over arm in the same cycle.
- Full, with pop in the same cycle: push accepted; level unchanged.
- Full, no pop: record discarded; drop_cnt += 1, saturating at 16'hFFFF.
- Empty, push and pop in the same cycle: no pop, since out_valid=0; push accepted.
- Empty, pop attempt: ignored.
- clear in the same cycle as push or pop: clear wins. FIFO empty and level=0 next cycle; the pushed record is lost and not counted as dropped.
- Pointers wrap modulo DEPTH. level is computed from pointers carrying one extra bit.
- reset_n asserted mid-capture or mid-drain: immediate return to reset values. No partial record is emitted.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- Defined:
  - Adds a free-running 32-bit cycle counter, reset to 0, incrementing every clk and wrapping at 2^32.
  - The counter value at the push cycle is stored with each record.
  - The stored value appears on the extra output port out_ts (32 bits), aligned with out_pc.
- Undefined: no counter, no out_ts port, and FIFO width is 97 bits.

Decomposition:
- Package trace_pkg contains:
  - the state encoding localparams: IDLE, CAPTURE, STOPPED;
  - RV_EBREAK = 32'h00100073;
  - TRACE_REC_W = 97, or 129 with TRACE_TIMESTAMP_EN;
  - field offset constants for packing and unpacking records.
- One sub-module, trace_fifo:
  - parameterised width/depth synchronous FIFO;
  - push/pop/flush ports, full/empty/level outputs, registered head.
- commit_trace_buffer holds the FSM, drop counter, optional timestamp counter and record packing.

Test Plan:
- Reset, arm, 3 retires (PC 0x0, 0x4, 0x8, reg_write=1), out_ready=1 -> 3 records in order. First record has out_valid=1 one cycle after its push; level returns to 0.
- DEPTH=16, STOP_ON_FULL=0, out_ready=0, 20 retires -> level=16, drop_cnt=4. Draining then returns PCs of the first 16 retires.
- Same test with STOP_ON_FULL=1 -> state=STOPPED when level=16; drop_cnt=0; further retires ignored.
- Retire instr 0x00100073 at PC 0x40 with EBREAK_STOP=1 -> record stored and state=STOPPED. The next retire, at PC 0x44, is not captured.
- Full FIFO, push and pop in the same cycle -> level stays 16, drop_cnt unchanged. Pulse clear together with push -> level=0, state=IDLE, drop_cnt=0.
- reset_n low for 1 cycle mid-drain with level=5 -> out_valid=0 and level=0 immediately; state=IDLE. With TRACE_TIMESTAMP_EN, out_ts of consecutive retires differ by 1.
